// File: rtl/sev_seg_scanner.sv
// rtl/sev_seg_scanner.sv - multiplexed 7-segment scanner with shadow/active digit buffers
// Optional blink feature: define SEV_SEG_BLINK_EN to add the blink port and frame counter.
module sev_seg_scanner #(
  parameter int NUM_DIGITS     = 5,
  parameter int REFRESH_CYCLES = 100000,
  parameter int DP_POS         = 2,
  parameter int BLINK_FRAMES   = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic                    load,
  input  logic                    blank_lz,
`ifdef SEV_SEG_BLINK_EN
  input  logic                    blink,
`endif
  output logic [6:0]              SEG,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    DP,
  output logic                    frame_done
);

  localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [TW-1:0] T_LAST = TW'(REFRESH_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] DP_IDX = IW'(DP_POS);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [TW-1:0]                 refresh_timer;
  logic [IW-1:0]                 idx;
  logic [NUM_DIGITS-1:0][3:0]    shadow;
  logic [NUM_DIGITS-1:0][3:0]    active;
  logic                          slot_end;
  logic                          wrap;
  logic [3:0]                    cur;
  logic                          run_zero;
  logic                          lz_blank;
  logic                          dark;
  logic                          blanked;
  logic [6:0]                    seg_dec;

  assign slot_end = (refresh_timer == T_LAST);
  assign wrap     = slot_end && (idx == I_LAST);

`ifdef SEV_SEG_BLINK_EN
  localparam int FW = $clog2(2 * BLINK_FRAMES) > 0 ? $clog2(2 * BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] F_HALF = FW'(BLINK_FRAMES);
  localparam logic [FW-1:0] F_LAST = FW'(2 * BLINK_FRAMES - 1);
  logic [FW-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (wrap) begin
      frame_cnt <= (frame_cnt == F_LAST) ? '0 : frame_cnt + 1'b1;
    end
  end

  assign dark = blink && (frame_cnt >= F_HALF);
`else
  assign dark = 1'b0;
`endif

  // A digit above the DP is zero-blanked only when it and every higher digit are zero.
  always_comb begin
    cur      = active[idx];
    run_zero = 1'b1;
    lz_blank = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run_zero = run_zero & (active[k] == 4'h0);
      if ((k > DP_POS) && run_zero && (IW'(k) == idx)) begin
        lz_blank = 1'b1;
      end
    end
    blanked = (cur > 4'd9) || (blank_lz && lz_blank) || dark;
    case (cur)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_timer <= '0;
      idx           <= '0;
      shadow        <= '1;
      active        <= '1;
      frame_done    <= 1'b0;
      SEG           <= 7'h7F;
      AN            <= '1;
      DP            <= 1'b1;
    end else begin
      refresh_timer <= slot_end ? '0 : refresh_timer + 1'b1;
      if (slot_end) begin
        idx <= wrap ? '0 : idx + 1'b1;
      end
      // Active takes the pre-edge shadow, so a same-cycle load waits one frame.
      if (wrap) begin
        active <= shadow;
      end
      if (load) begin
        shadow <= digits_bcd;
      end
      frame_done <= wrap;
      SEG        <= blanked ? 7'h7F : seg_dec;
      AN         <= blanked ? '1 : ~(AN_ONE << idx);
      DP         <= !(!blanked && (idx == DP_IDX));
    end
  end

endmodule

// File: tb/tb_sev_seg_scanner.sv
// tb/tb_sev_seg_scanner.sv - self-checking bench for sev_seg_scanner (5 digits, 4-cycle slots)
module tb_sev_seg_scanner;

  localparam int N  = 5;
  localparam int R  = 4;
  localparam int DPP = 2;
  localparam int FRAME = N * R;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] digits_bcd = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink = 1'b0;
  logic [6:0]  SEG;
  logic [4:0]  AN;
  logic        DP;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_cyc;
  logic [19:0] m_shadow;
  logic [19:0] m_active;
  logic [19:0] cur_d;

  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [19:0] d;
    bit          blz;
    int          k;
    logic [6:0]  seg;
    logic [4:0]  an;
    logic        dp;
  } vec_t;
  vec_t vt [14];

  sev_seg_scanner #(
    .NUM_DIGITS(N), .REFRESH_CYCLES(R), .DP_POS(DPP), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .digits_bcd(digits_bcd), .load(load),
    .blank_lz(blank_lz),
`ifdef SEV_SEG_BLINK_EN
    .blink(blink),
`endif
    .SEG(SEG), .AN(AN), .DP(DP), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  // Expected {SEG, AN, DP} for digit slot k of display value a.
  function automatic logic [12:0] disp(input logic [19:0] a, input int k, input bit blz, input bit drk);
    logic [3:0] d;
    bit all_zero;
    d = a[k*4 +: 4];
    all_zero = 1'b1;
    for (int j = k; j < N; j++) if (a[j*4 +: 4] != 4'h0) all_zero = 1'b0;
    if (d > 4'd9 || (blz && k > DPP && all_zero) || drk) return {7'h7F, 5'h1F, 1'b1};
    return {segtab[d], ~(5'b00001 << k), (k == DPP) ? 1'b0 : 1'b1};
  endfunction

  task automatic step(input bit ld, input logic [19:0] d, input bit blz);
    logic [12:0] e;
    bit wrap;
    bit drk;
    load = ld;
    digits_bcd = d;
    blank_lz = blz;
    drk = blink && (((m_cyc / FRAME) % 4) >= 2);
    e = disp(m_active, (m_cyc / R) % N, blz, drk);
    wrap = (m_cyc % FRAME) == FRAME - 1;
    if (wrap) m_active = m_shadow;
    if (ld) m_shadow = d;
    m_cyc++;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    chk("seg", {1'b0, SEG}, {1'b0, e[12:6]});
    chk("an", {3'b0, AN}, {3'b0, e[5:1]});
    chk("dp", {7'b0, DP}, {7'b0, e[0]});
    chk("frame_done", {7'b0, frame_done}, {7'b0, wrap});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_cyc = 0;
    m_shadow = '1;
    m_active = '1;
    chk("rst_seg", {1'b0, SEG}, 8'h7F);
    chk("rst_an", {3'b0, AN}, 8'h1F);
    chk("rst_dp", {7'b0, DP}, 8'h01);
    chk("rst_fd", {7'b0, frame_done}, 8'h00);
  endtask

  // Step until the outputs show slot k.
  task automatic goto_slot(input int k, input bit blz);
    bit reached = 1'b0;
    for (int i = 0; i < 2 * FRAME && !reached; i++) begin
      step(1'b0, cur_d, blz);
      if ((((m_cyc - 1) % FRAME) / R) == k) reached = 1'b1;
    end
    chk("slot_reach", {7'b0, reached}, 8'h01);
  endtask

  task automatic load_and_wrap(input logic [19:0] d, input bit blz);
    cur_d = d;
    step(1'b1, d, blz);
    for (int i = 0; i < FRAME + 2; i++) begin
      step(1'b0, d, blz);
      if (m_cyc % FRAME == 0) break;
    end
  endtask

  initial begin
    vt[0]  = '{20'h12345, 0, 0, 7'h12, 5'b11110, 1'b1};
    vt[1]  = '{20'h12345, 0, 1, 7'h19, 5'b11101, 1'b1};
    vt[2]  = '{20'h12345, 0, 2, 7'h30, 5'b11011, 1'b0};
    vt[3]  = '{20'h12345, 0, 3, 7'h24, 5'b10111, 1'b1};
    vt[4]  = '{20'h12345, 0, 4, 7'h79, 5'b01111, 1'b1};
    vt[5]  = '{20'h00705, 1, 4, 7'h7F, 5'b11111, 1'b1};
    vt[6]  = '{20'h00705, 1, 3, 7'h7F, 5'b11111, 1'b1};
    vt[7]  = '{20'h00705, 1, 2, 7'h78, 5'b11011, 1'b0};
    vt[8]  = '{20'h00705, 1, 1, 7'h40, 5'b11101, 1'b1};
    vt[9]  = '{20'h00005, 1, 2, 7'h40, 5'b11011, 1'b0};
    vt[10] = '{20'h00005, 1, 3, 7'h7F, 5'b11111, 1'b1};
    vt[11] = '{20'h1A345, 0, 3, 7'h7F, 5'b11111, 1'b1};
    vt[12] = '{20'h1A345, 0, 4, 7'h79, 5'b01111, 1'b1};
    vt[13] = '{20'h1A345, 0, 2, 7'h30, 5'b11011, 1'b0};

    repeat (2) @(negedge clk);
    do_reset();

    // Display stays blank until the first frame boundary after a load.
    cur_d = 20'h12345;
    step(1'b1, cur_d, 1'b0);
    chk("pre_frame_blank", {1'b0, SEG}, 8'h7F);

    for (int v = 0; v < 14; v++) begin
      load_and_wrap(vt[v].d, vt[v].blz);
      goto_slot(vt[v].k, vt[v].blz);
      chk($sformatf("vec%0d_seg", v), {1'b0, SEG}, {1'b0, vt[v].seg});
      chk($sformatf("vec%0d_an", v), {3'b0, AN}, {3'b0, vt[v].an});
      chk($sformatf("vec%0d_dp", v), {7'b0, DP}, {7'b0, vt[v].dp});
    end

    // Load on the terminal cycle of a frame lands one frame late.
    load_and_wrap(20'h11111, 1'b0);
    for (int i = 0; i < FRAME && (m_cyc % FRAME) != FRAME - 1; i++) step(1'b0, cur_d, 1'b0);
    cur_d = 20'h99999;
    step(1'b1, cur_d, 1'b0);
    chk("wrap_load_fd", {7'b0, frame_done}, 8'h01);
    goto_slot(0, 1'b0);
    chk("wrap_load_old", {1'b0, SEG}, 8'h79);
    for (int i = 0; i < FRAME && (m_cyc % FRAME) != 0; i++) step(1'b0, cur_d, 1'b0);
    goto_slot(0, 1'b0);
    chk("wrap_load_new", {1'b0, SEG}, 8'h10);

    // Reset mid-frame at slot 3, then time the first frame_done.
    goto_slot(3, 1'b0);
    do_reset();
    begin
      int cnt = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 3 * FRAME && !seen; i++) begin
        step(1'b0, cur_d, 1'b0);
        cnt++;
        if (frame_done) seen = 1'b1;
      end
      chk("reset_to_fd", 8'(cnt), 8'(FRAME));
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      logic [19:0] d;
      for (int j = 0; j < N; j++) begin
        int r = $urandom_range(0, 9);
        d[j*4 +: 4] = (r < 4) ? 4'h0 : ((r == 9) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)));
      end
`ifdef SEV_SEG_BLINK_EN
      blink = (i < 600) ? 1'b1 : (i < 1000) ? 1'b0 : 1'($urandom_range(0, 1));
`endif
      step(($urandom_range(0, 7) == 0), d, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sev_seg_scanner.md
SEV_SEG_SCANNER -- requirements
Module: sev_seg_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 5: digit count, legal 2..8.
REQ-002 SHALL have parameter REFRESH_CYCLES, default 100000: clk cycles per digit slot, legal >= 2.
REQ-003 SHALL have parameter DP_POS, default 2: digit index that drives the decimal point, legal 0..NUM_DIGITS-1.
REQ-004 SHALL have parameter BLINK_FRAMES, default 64: frames per blink half-period, used only with SEV_SEG_BLINK_EN.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port digits_bcd, input, 4*NUM_DIGITS: BCD digits, nibble k is digit k, nibble 0 least significant.
REQ-008 SHALL have port load, input, 1: capture strobe for digits_bcd.
REQ-009 SHALL have port blank_lz, input, 1: leading-zero blanking enable.
REQ-010 SHALL have port SEG, output, 7: segments, active low, bit 0 is segment a.
REQ-011 SHALL have port AN, output, NUM_DIGITS: anodes, active low, AN[k] drives digit k.
REQ-012 SHALL have port DP, output, 1: decimal point, active low.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse at each frame boundary.

Function
REQ-014 SHALL keep refresh_timer counting 0..REFRESH_CYCLES-1; at terminal count it wraps to 0 and scan index idx advances by one.
REQ-015 SHALL wrap idx from NUM_DIGITS-1 to 0 (frame wrap); idx values >= NUM_DIGITS are never reached.
REQ-016 SHALL capture digits_bcd into the shadow register on any cycle with load=1; the last load wins.
REQ-017 SHALL copy shadow into active on the frame-wrap cycle; a load in that same cycle updates shadow only and takes effect next frame.
REQ-018 SHALL pulse frame_done high for exactly the frame-wrap cycle.
REQ-019 SHALL register SEG/AN/DP: the outputs reflect idx and active one cycle after they change.
REQ-020 SHALL drive exactly one AN bit low (bit idx) unless the digit is blanked; when blanked, AN is all ones and SEG is 7'h7F.
REQ-021 SHALL decode 0-9 with the standard active-low patterns (0=7'h40, 1=7'h79, 8=7'h00); codes A-F blank the digit.
REQ-022 SHALL blank digit k, when blank_lz=1, if k>DP_POS and active digits k..NUM_DIGITS-1 are all zero; digits at or below DP_POS are never zero-blanked.
REQ-023 SHALL drive DP=0 only while idx==DP_POS and that digit is not blanked; otherwise DP=1.
REQ-024 SHALL sample blank_lz combinationally each cycle, with effect on the next registered output.

Reset
REQ-025 SHALL on reset=1 set refresh_timer=0, idx=0, shadow=active=all 4'hF, frame_done=0, SEG=7'h7F, AN=all ones, DP=1.
REQ-026 SHALL let reset override load and frame wrap in the same cycle, including mid-frame; the count restarts at 0 on the cycle after reset deasserts.

Configuration
REQ-027 SHALL, with macro SEV_SEG_BLINK_EN defined, add input port blink (1 bit) and a frame counter that runs modulo 2*BLINK_FRAMES and is cleared by reset.
REQ-028 SHALL, with SEV_SEG_BLINK_EN defined and blink=1, blank all digits and the DP while the frame counter is >= BLINK_FRAMES; blink=0 displays normally and does not stop the counter.
REQ-029 SHALL, without SEV_SEG_BLINK_EN, have no blink port and no frame counter; the display is never blink-blanked.

Verification (NUM_DIGITS=5, REFRESH_CYCLES=4, DP_POS=2)
REQ-030 SHALL check: reset, then load=1 for one cycle with digits_bcd=20'h12345 -> blank until the first frame_done; the next frame shows AN=11110/SEG=7'h12, ..., AN=01111/SEG=7'h79, with DP=0 only in the AN=11011 slot.
REQ-031 SHALL check: blank_lz=1, digits_bcd=20'h00705 -> digits 4 and 3 blanked (AN all ones), digit 2 shows 7 with DP=0; 20'h00005 -> digit 2 shows 0 with DP=0.
REQ-032 SHALL check: load asserted on the frame-wrap cycle with 20'h99999 while shadow=20'h11111 -> the next frame shows 1s and the following frame shows 9s.
REQ-033 SHALL check: digits_bcd=20'h1A345 -> the digit 3 slot shows SEG=7'h7F, AN=11111; other digits are unaffected.
REQ-034 SHALL check: reset asserted mid-frame at idx=3 -> the next cycle shows AN=11111, SEG=7'h7F, frame_done=0; after release, the first frame_done occurs exactly 20 cycles later.
REQ-035 SHALL check, with SEV_SEG_BLINK_EN and BLINK_FRAMES=2: blink=1 -> frames 0-1 lit and frames 2-3 dark, repeating; blink=0 -> all frames lit.
